// File: rtl/rarp_pkg.sv
// Shared RARP protocol constants, word-index type, scheduler states and the
// payload word mux used by the transmit scheduler.
package rarp_pkg;

    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN_ETH      = 8'd6;
    localparam logic [7:0]  PLEN_IPV4     = 8'd4;
    localparam logic [15:0] OP_RARP_REQ   = 16'd3;
    localparam logic [15:0] OP_RARP_REPLY = 16'd4;

    localparam int WORDS_PER_FRAME = 7;
    typedef logic [2:0] word_idx_t;
    localparam word_idx_t LAST_IDX = word_idx_t'(WORDS_PER_FRAME - 1);

    typedef enum logic {ST_IDLE, ST_SEND} state_e;

    // 7:1 selection of one payload word straight from the individual frame fields.
    function automatic logic [31:0] rarp_word(input word_idx_t   idx,
                                              input logic [15:0] oper,
                                              input logic [47:0] sha,
                                              input logic [31:0] spa,
                                              input logic [47:0] tha,
                                              input logic [31:0] tpa);
        logic [31:0] w;
        case (idx)
            3'd0:    w = {HTYPE_ETH, PTYPE_IPV4};
            3'd1:    w = {HLEN_ETH, PLEN_IPV4, oper};
            3'd2:    w = sha[47:16];
            3'd3:    w = {sha[15:0], spa[31:16]};
            3'd4:    w = {spa[15:0], tha[47:32]};
            3'd5:    w = tha[31:0];
            3'd6:    w = tpa;
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/rarp_tx_sched_if.sv
// 32-bit transmit word stream with valid/ready handshake and end-of-frame marker.
interface rarp_tx_sched_if;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready;

    modport master (output tx_data, output tx_valid, output tx_last, input tx_ready);
    modport slave  (input tx_data, input tx_valid, input tx_last, output tx_ready);
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot pick, registered pointer
// that moves to the other requester when the current owner finishes.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       adv,
    input  logic       adv_id,
    output logic [1:0] pick
);
    logic rr_q, rr_d;

    always_comb begin
        rr_d = rr_q;
        if (adv) rr_d = ~adv_id;
    end

    always_comb begin
        if (req == 2'b11) pick = rr_q ? 2'b10 : 2'b01;
        else              pick = req;
    end

    always_ff @(posedge clk) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end
endmodule

// File: rtl/rarp_tx_sched.sv
// Arbitrates RARP request/reply senders onto one 32-bit stream, capturing the
// frame fields at grant time and emitting the 28-byte payload as seven words.
module rarp_tx_sched
    import rarp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] cfg_mac,
    input  logic [31:0] cfg_ip,
    input  logic [1:0]  req,
    input  logic [47:0] req_tha0,
    input  logic [31:0] req_tpa0,
    input  logic [47:0] req_tha1,
    input  logic [31:0] req_tpa1,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        busy,
    rarp_tx_sched_if.master tx
);
    state_e      state_q, state_d;
    word_idx_t   idx_q, idx_d;
    logic        owner_q, owner_d;
    logic [15:0] oper_q, oper_d;
    logic [47:0] sha_q, sha_d;
    logic [31:0] spa_q, spa_d;
    logic [47:0] tha_q, tha_d;
    logic [31:0] tpa_q, tpa_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic        busy_q, busy_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic [31:0] data_q, data_d;
    logic [1:0]  pick;
    logic        adv;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .adv    (adv),
        .adv_id (owner_q),
        .pick   (pick)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        owner_d = owner_q;
        oper_d  = oper_q;
        sha_d   = sha_q;
        spa_d   = spa_q;
        tha_d   = tha_q;
        tpa_d   = tpa_q;
        gnt_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        valid_d = valid_q;
        last_d  = last_q;
        adv     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    state_d = ST_SEND;
                    idx_d   = '0;
                    owner_d = pick[1];
                    oper_d  = pick[1] ? OP_RARP_REPLY : OP_RARP_REQ;
                    sha_d   = cfg_mac;
                    spa_d   = pick[1] ? cfg_ip : 32'd0;
                    tha_d   = pick[1] ? req_tha1 : req_tha0;
                    tpa_d   = pick[1] ? req_tpa1 : req_tpa0;
                    gnt_d   = pick;
                    busy_d  = 1'b1;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end
            end
            ST_SEND: begin
                if (valid_q && tx.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                        busy_d  = 1'b0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        done_d  = owner_q ? 2'b10 : 2'b01;
                        adv     = 1'b1;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        last_d = (idx_d == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // The word is precomputed from next-state values so tx_data is a flop.
        data_d = (state_d == ST_SEND) ? rarp_word(idx_d, oper_d, sha_d, spa_d, tha_d, tpa_d)
                                      : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            owner_q <= 1'b0;
            oper_q  <= '0;
            sha_q   <= '0;
            spa_q   <= '0;
            tha_q   <= '0;
            tpa_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            owner_q <= owner_d;
            oper_q  <= oper_d;
            sha_q   <= sha_d;
            spa_q   <= spa_d;
            tha_q   <= tha_d;
            tpa_q   <= tpa_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign gnt         = gnt_q;
    assign done        = done_q;
    assign busy        = busy_q;
    assign tx.tx_data  = data_q;
    assign tx.tx_valid = valid_q;
    assign tx.tx_last  = last_q;
endmodule

// File: tb/tb_rarp_tx_sched.sv
// Randomized bench for rarp_tx_sched: a byte-level RARP payload model and a
// round-robin expectation predict every grant, word, last flag and done pulse.
module tb_rarp_tx_sched;
    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] cfg_mac;
    logic [31:0] cfg_ip;
    logic [1:0]  req;
    logic [47:0] req_tha0, req_tha1;
    logic [31:0] req_tpa0, req_tpa1;
    logic [1:0]  gnt, done;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int rrModel  = 0;
    logic [31:0] expWords [7];
    logic [31:0] gotWords [7];

    rarp_tx_sched_if txIf ();

    rarp_tx_sched dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_mac  (cfg_mac),
        .cfg_ip   (cfg_ip),
        .req      (req),
        .req_tha0 (req_tha0),
        .req_tpa0 (req_tpa0),
        .req_tha1 (req_tha1),
        .req_tpa1 (req_tpa1),
        .gnt      (gnt),
        .done     (done),
        .busy     (busy),
        .tx       (txIf)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [47:0] rand48();
        return {16'($urandom), 32'($urandom)};
    endfunction

    // Payload as 28 network-order bytes, then cut into big-endian 32-bit words.
    function automatic void buildFrame(input int k, input logic [47:0] sha, input logic [31:0] spa,
                                       input logic [47:0] tha, input logic [31:0] tpa);
        logic [7:0] b [28];
        b[0] = 8'h00; b[1] = 8'h01; b[2] = 8'h08; b[3] = 8'h00;
        b[4] = 8'd6;  b[5] = 8'd4;  b[6] = 8'h00; b[7] = (k == 1) ? 8'd4 : 8'd3;
        for (int i = 0; i < 6; i++) b[8 + i]  = sha[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) b[14 + i] = spa[31 - 8*i -: 8];
        for (int i = 0; i < 6; i++) b[18 + i] = tha[47 - 8*i -: 8];
        for (int i = 0; i < 4; i++) b[24 + i] = tpa[31 - 8*i -: 8];
        for (int w = 0; w < 7; w++) expWords[w] = {b[4*w], b[4*w+1], b[4*w+2], b[4*w+3]};
    endfunction

    // Runs one frame starting at a negedge with the DUT idle; returns at the
    // negedge of the done cycle (or right after an injected reset).
    task automatic applyStimulus(input logic [1:0] r, input int readyMode, input int resetAt, input bit scramble);
        int   k, hs, cyc;
        logic [31:0] held;
        logic heldLast;
        bit   holdPending;
        k = (r == 2'b11) ? rrModel : (r[1] ? 1 : 0);
        buildFrame(k, cfg_mac, (k == 1) ? cfg_ip : 32'd0,
                   (k == 1) ? req_tha1 : req_tha0, (k == 1) ? req_tpa1 : req_tpa0);
        req = r;
        txIf.tx_ready = 1'b0;
        @(negedge clk);
        checkOutput("gnt", 64'(gnt), 64'(2'b01 << k));
        checkOutput("busyStart", 64'(busy), 64'd1);
        checkOutput("doneAtGnt", 64'(done), 64'd0);
        if (scramble) begin
            cfg_mac  = rand48();
            cfg_ip   = $urandom;
            req_tha0 = rand48(); req_tpa0 = $urandom;
            req_tha1 = rand48(); req_tpa1 = $urandom;
        end
        hs = 0; cyc = 0; holdPending = 0; held = '0; heldLast = 1'b0;
        while (hs < 7 && cyc < 200) begin
            checkOutput("valid", 64'(txIf.tx_valid), 64'd1);
            if (cyc > 0) checkOutput("gntInFrame", 64'(gnt), 64'd0);
            checkOutput("doneInFrame", 64'(done), 64'd0);
            if (holdPending) begin
                checkOutput("holdData", 64'(txIf.tx_data), 64'(held));
                checkOutput("holdLast", 64'(txIf.tx_last), 64'(heldLast));
            end
            if (resetAt == hs) begin
                checkOutput("wordBeforeRst", 64'(txIf.tx_data), 64'(expWords[hs]));
                txIf.tx_ready = 1'b0;
                rst = 1'b1;
                @(negedge clk);
                checkOutput("rstValid", 64'(txIf.tx_valid), 64'd0);
                checkOutput("rstDone", 64'(done), 64'd0);
                checkOutput("rstBusy", 64'(busy), 64'd0);
                rst = 1'b0;
                rrModel = 0;
                return;
            end
            case (readyMode)
                0:       txIf.tx_ready = 1'b1;
                1:       txIf.tx_ready = (cyc % 3 == 0);
                default: txIf.tx_ready = 1'($urandom);
            endcase
            if (txIf.tx_ready) begin
                checkOutput($sformatf("word%0d", hs), 64'(txIf.tx_data), 64'(expWords[hs]));
                checkOutput($sformatf("last%0d", hs), 64'(txIf.tx_last), 64'(hs == 6));
                gotWords[hs] = txIf.tx_data;
                hs++;
                holdPending = 0;
            end else begin
                holdPending = 1;
                held = txIf.tx_data;
                heldLast = txIf.tx_last;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("handshakes", 64'(hs), 64'd7);
        checkOutput("done", 64'(done), 64'(2'b01 << k));
        checkOutput("busyEnd", 64'(busy), 64'd0);
        checkOutput("validEnd", 64'(txIf.tx_valid), 64'd0);
        checkOutput("gntAtDone", 64'(gnt), 64'd0);
        if (readyMode == 0) checkOutput("frameCycles", 64'(cyc), 64'd7);
        rrModel = 1 - k;
        txIf.tx_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 2'b00; txIf.tx_ready = 1'b0;
        cfg_mac = '0; cfg_ip = '0;
        req_tha0 = '0; req_tpa0 = '0; req_tha1 = '0; req_tpa1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rstGnt", 64'(gnt), 64'd0);
        checkOutput("rstDoneInit", 64'(done), 64'd0);
        checkOutput("rstBusyInit", 64'(busy), 64'd0);
        checkOutput("rstValidInit", 64'(txIf.tx_valid), 64'd0);
        checkOutput("rstLastInit", 64'(txIf.tx_last), 64'd0);
        checkOutput("rstDataInit", 64'(txIf.tx_data), 64'd0);
        rst = 1'b0;

        cfg_mac = 48'h0011_2233_4455; cfg_ip = 32'hC0A8_0001;
        req_tha0 = 48'h0011_2233_4455; req_tpa0 = 32'd0;
        applyStimulus(2'b01, 0, -1, 0);
        checkOutput("dirReqW0", 64'(gotWords[0]), 64'h0001_0800);
        checkOutput("dirReqW1", 64'(gotWords[1]), 64'h0604_0003);
        checkOutput("dirReqW3", 64'(gotWords[3]), 64'h4455_0000);
        checkOutput("dirReqW4", 64'(gotWords[4]), 64'h0000_0011);

        req_tha1 = 48'hAABB_CCDD_EEFF; req_tpa1 = 32'hC0A8_0063;
        applyStimulus(2'b10, 0, -1, 0);
        checkOutput("dirRepW1", 64'(gotWords[1]), 64'h0604_0004);
        checkOutput("dirRepW3", 64'(gotWords[3]), 64'h4455_C0A8);
        checkOutput("dirRepW4", 64'(gotWords[4]), 64'h0001_AABB);
        checkOutput("dirRepW6", 64'(gotWords[6]), 64'hC0A8_0063);

        for (int i = 0; i < 4; i++) applyStimulus(2'b11, 0, -1, 0);
        applyStimulus(2'b01, 1, -1, 0);
        applyStimulus(2'b01, 0, -1, 1);

        applyStimulus(2'b01, 0, -1, 0);
        applyStimulus(2'b10, 0, 3, 0);
        applyStimulus(2'b11, 0, -1, 0);

        for (int i = 0; i < 30; i++) begin
            logic [1:0] r;
            r = 2'($urandom_range(1, 3));
            cfg_mac  = rand48(); cfg_ip = $urandom;
            req_tha0 = rand48(); req_tpa0 = $urandom;
            req_tha1 = rand48(); req_tpa1 = $urandom;
            applyStimulus(r, int'($urandom_range(0, 2)), -1, 1'($urandom));
        end
        req = 2'b00;
        @(negedge clk);
        checkOutput("idleAfter", 64'(busy), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rarp_tx_sched.md
# rarp_tx_sched

Frame scheduler and arbiter in front of the RARP transmit path. It shares one 32-bit transmit word stream between two requesters: requester 0 issues RARP requests and requester 1 issues RARP replies. For the granted requester it builds the 28-byte RARP payload from captured fields and station configuration. It then emits the payload as seven 32-bit words under a valid/ready handshake.

## Interface
Parameters:
- none. All protocol constants come from `rarp_pkg`.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous, active-high.
- `cfg_mac`  in  48  own hardware address (SHA).
- `cfg_ip`  in  32  own protocol address. Used as SPA for replies.
- `req`  in  2  frame request. `req[0]` is RARP request; `req[1]` is RARP reply. Held until the matching `gnt` bit.
- `req_tha0`, `req_tpa0`  in  48 / 32  target HW / IP address for requester 0.
- `req_tha1`, `req_tpa1`  in  48 / 32  target HW / IP address for requester 1.
- `gnt`  out  2  one-cycle grant pulse.
- `done`  out  2  one-cycle pulse after the frame's last word is accepted.
- `busy`  out  1  high while a frame is in flight.
- `tx_data`  out  32  payload word.
- `tx_valid`  out  1  `tx_data` is valid.
- `tx_last`  out  1  marks word 6.
- `tx_ready`  in  1  downstream accepts the word.

## Operation
- **States:** IDLE, SEND.
- **IDLE:**
  - If `req != 0`, the arbiter picks one requester. With both requesting, the round-robin pointer `rr` decides; `rr` resets to 0.
  - On the pick edge the block captures into the frame registers: opcode, SHA=`cfg_mac`, SPA, THA, TPA.
  - SPA is 0 for requester 0 and `cfg_ip` for requester 1.
  - Next state is SEND with word index `idx`=0.
- **SEND:**
  - `tx_valid`=1 and `tx_data`=word[`idx`].
  - On `tx_valid & tx_ready`: if `idx`<6, then `idx`++. If `idx`==6, the next state is IDLE, `done[k]` pulses and `rr` is set to the other requester (`rr`=~k).
- **Word map:**
  - W0={HTYPE 16'h0001, PTYPE 16'h0800}
  - W1={HLEN 8'h06, PLEN 8'h04, OPER[15:0]}
  - W2=SHA[47:16]
  - W3={SHA[15:0], SPA[31:16]}
  - W4={SPA[15:0], THA[47:32]}
  - W5=THA[31:0]
  - W6=TPA
- **OPER values:** 16'd3 for requester 0, 16'd4 for requester 1.
- **Sampling:**
  - `req`, `req_*` and `cfg_*` are sampled only on the grant edge. Later changes do not affect the frame in flight.
  - `req` is ignored outside IDLE.
  - A requester that drops `req` before being granted is simply not served.
- **Back-pressure:** while `tx_valid` is high and `tx_ready` is low, `tx_data`, `tx_last` and `idx` hold.
- **Reset:**
  - Every output resets to 0: `gnt`, `done`, `busy`, `tx_valid`, `tx_last`, `tx_data`.
  - State returns to IDLE, `idx`=0 and `rr`=0.
  - Reset mid-frame drops `tx_valid` on the next edge. No `done` is issued for the aborted frame.

## Timing
- All outputs are registered.
- A `req` seen in IDLE at edge N gives SEND from N+1. `gnt[k]`, `busy` and the first `tx_valid` (W0) all assert in cycle N+1. `gnt` is a one-cycle pulse.
- With `tx_ready` held high, W0..W6 appear in cycles N+1..N+7. `tx_last` is asserted with W6.
- The last handshake happens at the end of cycle N+7. In cycle N+8, `done[k]`=1 and `busy`=0, with the block back in IDLE.
- A `req` present in cycle N+8 is granted with W0 in N+9. The minimum frame period is 8 cycles, with one idle cycle between frames.
- `busy` = (state==SEND).
- `gnt` and `done` are mutually exclusive per cycle.

## Structure
- **`rarp_pkg`** holds:
  - `HTYPE_ETH`=16'h0001, `PTYPE_IPV4`=16'h0800, `HLEN_ETH`=8'd6, `PLEN_IPV4`=8'd4
  - `OP_RARP_REQ`=16'd3, `OP_RARP_REPLY`=16'd4
  - `WORDS_PER_FRAME`=7 and the 3-bit word-index type
  - the state enum {`ST_IDLE`, `ST_SEND`}
- **Sub-module `rr_arb2`:** 2-way round-robin arbiter with inputs `req[1:0]` and `rr`, output one-hot `pick[1:0]`, and an advance strobe. Combinational pick, registered pointer. It is reusable by the later ARP/RARP merge.
- Word selection is a 7:1 mux on `idx` over the frame registers. The frame registers are not stored as a pre-packed 224-bit word.

## Test plan
- **Single request, no back-pressure:** setup is `rst` then `cfg_mac`=48'h0011_2233_4455, `cfg_ip`=32'hC0A8_0001, with `req`=2'b01, `req_tha0`=48'h0011_2233_4455, `req_tpa0`=0. Required words: 32'h0001_0800, 32'h0604_0003, 32'h0011_2233, 32'h4455_0000, 32'h0000_0011, 32'h2233_4455, 32'h0000_0000. Required pulses: `tx_last` on W6, `done`=2'b01 one cycle later.
- **Reply:** `req`=2'b10, `req_tha1`=48'hAABB_CCDD_EEFF, `req_tpa1`=32'hC0A8_0063. Required: W1=32'h0604_0004, W3=32'h4455_C0A8, W4=32'h0001_AABB, W6=32'hC0A8_0063.
- **Simultaneous requests:** both `req` bits held continuously after reset. Required grant order 0, 1, 0, 1 with an 8-cycle period, and no `gnt`/`done` overlap.
- **Back-pressure:** toggle `tx_ready` with the pattern 1,0,0,1,... Required: each word is held stable while not ready, exactly 7 handshakes occur, and `done` follows the 7th.
- **Mid-frame field change:** change `req_tpa0` and `cfg_mac` during SEND. Required: the frame carries the values captured at the grant edge.
- **Reset at W3:** assert `rst` while W3 is on the bus. Required: `tx_valid`=0 next cycle, no `done` pulse, and a fresh request afterwards restarts at W0 with requester 0 taking priority.
